uart_serdes: RTL and testbench
==============================

# uart_serdes

Bit-level 8N1 UART transceiver that sits directly below the UART device controller. It serializes one byte per `data_send`/`data_sent` handshake onto `uart_txd`. It deserializes `uart_rxd` frames into `data_out` with a one-cycle `data_received` strobe, which the controller registers into its receive FIFO. Transmit and receive paths are independent and run concurrently; there is no internal buffering beyond one byte per direction.

## Interface
- `CLKS_PER_BIT`, default 868; clock cycles per bit (100 MHz / 115200). Legal range is ≥ 4.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high.
- `uart_rxd`  in  1  serial input; asynchronous to `clk`.
- `uart_txd`  out  1  serial output; idles high.
- `data_in`  in  8  byte to transmit; sampled when a request is accepted.
- `data_send`  in  1  transmit request level.
- `data_sent`  out  1  one-cycle pulse: frame finished.
- `data_out`  out  8  last received byte; held until the next good frame.
- `data_received`  out  1  one-cycle pulse: `data_out` updated this cycle.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- Frame format: start bit (0), then 8 data bits LSB first, then one stop bit (1). No parity.
- TX FSM states: `TX_IDLE`, `TX_START`, `TX_DATA`, `TX_STOP`, `TX_DONE`.
  - `TX_IDLE`: if `data_send`=1, latch `data_in` into the shift register and go to `TX_START`.
  - `TX_START`, `TX_DATA`, `TX_STOP` each hold a bit for `CLKS_PER_BIT` cycles. `TX_DATA` uses a 3-bit index 0..7.
  - `TX_DONE` lasts 1 cycle. It asserts `data_sent`, then goes to `TX_IDLE`.
  - The requester must deassert `data_send` in the cycle after `data_sent`. If it is still high in `TX_IDLE`, a new frame starts.
- `uart_txd` is registered, and is 1 in every state except `TX_START`/`TX_DATA`.
- RX input passes through a 2-flop synchronizer with reset value 1. Edge detection uses the synchronized value only.
- RX FSM states: `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`, `RX_BREAK`.
  - `RX_IDLE` → `RX_START` on a synchronized falling edge (1→0). The bit counter is cleared.
  - `RX_START` resamples at count `CLKS_PER_BIT/2` (integer division). If the line is 1, treat it as a glitch and return to `RX_IDLE`. If 0, restart the count and go to `RX_DATA`.
  - `RX_DATA`: sample every `CLKS_PER_BIT` cycles (mid-bit) and shift in LSB first. After the 8th sample, go to `RX_STOP`.
  - `RX_STOP`: sample after `CLKS_PER_BIT`.
    - Sample 1: load `data_out` and pulse `data_received` in the next cycle, then go to `RX_IDLE`.
    - Sample 0: pulse `frame_error`, leave `data_out` unchanged, and go to `RX_BREAK`.
  - `RX_BREAK` → `RX_IDLE` once the synchronized line is 1.
- The counter width is `$clog2(CLKS_PER_BIT)`. It counts up from 0 to `CLKS_PER_BIT-1` and never wraps mid-bit.

## Timing
- Reset values: `uart_txd`=1, `data_sent`=0, `data_out`=8'h00, `data_received`=0, `frame_error`=0. Both FSMs are idle and the synchronizer is 2'b11.
- Reset mid-frame aborts immediately. `uart_txd` is 1 in the cycle after the reset edge, and any partial RX byte is discarded with no pulses.
- TX: acceptance edge at cycle t0.
  - `uart_txd`=0 during cycles t0+1 .. t0+N.
  - Bit k occupies cycles t0+1+(k+1)N .. t0+(k+2)N.
  - The stop bit ends at cycle t0+10N.
  - `data_sent`=1 in cycle t0+10N+1.
  - The earliest next start bit is at t0+10N+3.
- RX: let f be the cycle the synchronized falling edge is seen; the raw line fell 2–3 cycles earlier.
  - Data bit k is sampled at about f+N/2+(k+1)N.
  - Stop is sampled at f+N/2+9N.
  - `data_received`/`frame_error` fires 1 cycle after the stop sample.
  - RX re-arms before the stop bit ends, so back-to-back frames are received.
- Simultaneous TX and RX activity has no interaction.
- `data_received` and `frame_error` are never asserted together.

## Structure
- Shared package `uart_pkg` holds:
  - TX/RX state enums
  - `UART_DATA_BITS`=8
  - the default `CLKS_PER_BIT`
- Sub-module `uart_sync`: 2-flop synchronizer with a reset-value parameter; it is reused by other async inputs.
- TX and RX stay as two FSM blocks in this module. Target size is about 200 lines.

## Test plan
- `CLKS_PER_BIT`=16 for all tests.
- Send 8'hA5: pulse `data_send` at t0 → `uart_txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; `data_sent` at t0+161; no second frame.
- Hold `data_send` high through `data_sent` → a second frame starts at t0+163 with the new `data_in`.
- Drive an RX frame of 8'h3C with exact timing, back to back with 8'hFF → two `data_received` pulses; `data_out`=8'h3C, then 8'hFF; `frame_error` stays 0.
- RX glitch low for 4 cycles → no pulses and FSM back in `RX_IDLE`. A stop bit forced to 0 → `frame_error` pulse; `data_out` keeps its previous value. Holding the line low 40 cycles afterward produces no new frame until it returns high.
- Assert `rst` mid-TX at bit 3 and mid-RX at bit 5 → `uart_txd`=1 in the next cycle, all pulses 0, `data_out`=8'h00; a following clean frame is received correctly.
- Full-duplex run: TX 8'h55 concurrently with RX 8'hAA, skewed by 7 cycles → both complete with correct values and no cross-interference.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART bit-level transceiver.
// Holds the TX/RX state encodings, the frame data width and the default bit period.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_IDX_W                = $clog2(UART_DATA_BITS);
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// RST_VAL loads both flops so the output starts at the line's idle level.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  // Shift the raw input through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {2{RST_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_async};
    end
  end

  assign o_sync = r_sync[1];

endmodule

// File: rtl/uart_serdes.sv
// 8N1 UART bit engine: independent TX serializer and RX deserializer FSMs.
// One byte per direction in flight; all outputs are registered.
module uart_serdes
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uart_rxd,
  output logic                      uart_txd,
  input  logic [UART_DATA_BITS-1:0] data_in,
  input  logic                      data_send,
  output logic                      data_sent,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_received,
  output logic                      frame_error
);

  localparam int                   CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]        LP_CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]        LP_CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]        LP_CNT_ONE  = CW'(1);
  localparam logic [UART_IDX_W-1:0] LP_IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);
  localparam logic [UART_IDX_W-1:0] LP_IDX_ONE  = UART_IDX_W'(1);

  // ---------------- transmit ----------------
  tx_state_e                 r_tx_state;
  tx_state_e                 w_tx_next;
  logic [CW-1:0]             r_tx_cnt;
  logic [UART_IDX_W-1:0]     r_tx_idx;
  logic [UART_DATA_BITS-1:0] r_tx_data;
  logic                      r_txd;
  logic                      r_data_sent;
  logic                      w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == LP_CNT_LAST);

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  // TX next-state logic.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  w_tx_next = data_send ? TX_START : TX_IDLE;
      TX_START: w_tx_next = w_tx_bit_end ? TX_DATA : TX_START;
      TX_DATA:  w_tx_next = (w_tx_bit_end && (r_tx_idx == LP_IDX_LAST)) ? TX_STOP : TX_DATA;
      TX_STOP:  w_tx_next = w_tx_bit_end ? TX_DONE : TX_STOP;
      TX_DONE:  w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // TX bit timer, data latch and registered line/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_cnt    <= '0;
      r_tx_idx    <= '0;
      r_tx_data   <= '0;
      r_txd       <= 1'b1;
      r_data_sent <= 1'b0;
    end else begin
      r_data_sent <= (r_tx_state == TX_DONE);
      // Line level follows the current state, giving one cycle of latency from acceptance.
      case (r_tx_state)
        TX_START: r_txd <= 1'b0;
        TX_DATA:  r_txd <= r_tx_data[r_tx_idx];
        default:  r_txd <= 1'b1;
      endcase
      if ((r_tx_state == TX_IDLE) || (r_tx_state == TX_DONE)) begin
        r_tx_cnt <= '0;
        r_tx_idx <= '0;
        if ((r_tx_state == TX_IDLE) && data_send) begin
          r_tx_data <= data_in;
        end else begin
          r_tx_data <= r_tx_data;
        end
      end else begin
        r_tx_cnt <= w_tx_bit_end ? '0 : (r_tx_cnt + LP_CNT_ONE);
        if ((r_tx_state == TX_DATA) && w_tx_bit_end) begin
          r_tx_idx <= r_tx_idx + LP_IDX_ONE;
        end else begin
          r_tx_idx <= r_tx_idx;
        end
      end
    end
  end

  // ---------------- receive ----------------
  rx_state_e                 r_rx_state;
  rx_state_e                 w_rx_next;
  logic [CW-1:0]             r_rx_cnt;
  logic [UART_IDX_W-1:0]     r_rx_idx;
  logic [UART_DATA_BITS-1:0] r_rx_shift;
  logic [UART_DATA_BITS-1:0] r_data_out;
  logic                      r_rx_prev;
  logic                      r_data_received;
  logic                      r_frame_error;
  logic                      w_rx_line;
  logic                      w_rx_fall;
  logic                      w_rx_bit_end;
  logic                      w_rx_ok;
  logic                      w_rx_err;

  uart_sync #(.RST_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (uart_rxd),
    .o_sync  (w_rx_line)
  );

  assign w_rx_fall    = r_rx_prev & ~w_rx_line;
  assign w_rx_bit_end = (r_rx_cnt == LP_CNT_LAST);

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  // RX next-state logic and stop-bit verdict.
  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_ok   = 1'b0;
    w_rx_err  = 1'b0;
    case (r_rx_state)
      RX_IDLE:  w_rx_next = w_rx_fall ? RX_START : RX_IDLE;
      RX_START: begin
        if (r_rx_cnt == LP_CNT_HALF) begin
          w_rx_next = w_rx_line ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_next = RX_START;
        end
      end
      RX_DATA:  w_rx_next = (w_rx_bit_end && (r_rx_idx == LP_IDX_LAST)) ? RX_STOP : RX_DATA;
      RX_STOP: begin
        if (w_rx_bit_end) begin
          w_rx_ok   = w_rx_line;
          w_rx_err  = ~w_rx_line;
          w_rx_next = w_rx_line ? RX_IDLE : RX_BREAK;
        end else begin
          w_rx_next = RX_STOP;
        end
      end
      RX_BREAK: w_rx_next = w_rx_line ? RX_IDLE : RX_BREAK;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // RX bit timer, shift register and registered result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_cnt        <= '0;
      r_rx_idx        <= '0;
      r_rx_shift      <= '0;
      r_rx_prev       <= 1'b1;
      r_data_out      <= '0;
      r_data_received <= 1'b0;
      r_frame_error   <= 1'b0;
    end else begin
      r_rx_prev       <= w_rx_line;
      r_data_received <= w_rx_ok;
      r_frame_error   <= w_rx_err;
      if (w_rx_ok) begin
        r_data_out <= r_rx_shift;
      end else begin
        r_data_out <= r_data_out;
      end
      case (r_rx_state)
        RX_START: r_rx_cnt <= (r_rx_cnt == LP_CNT_HALF) ? '0 : (r_rx_cnt + LP_CNT_ONE);
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= r_rx_idx + LP_IDX_ONE;
            r_rx_shift <= {w_rx_line, r_rx_shift[UART_DATA_BITS-1:1]};
          end else begin
            r_rx_cnt   <= r_rx_cnt + LP_CNT_ONE;
          end
        end
        RX_STOP:  r_rx_cnt <= w_rx_bit_end ? '0 : (r_rx_cnt + LP_CNT_ONE);
        default: begin
          r_rx_cnt <= '0;
          r_rx_idx <= '0;
        end
      endcase
    end
  end

  assign uart_txd      = r_txd;
  assign data_sent     = r_data_sent;
  assign data_out      = r_data_out;
  assign data_received = r_data_received;
  assign frame_error   = r_frame_error;

endmodule

// File: tb/tb_uart_serdes.sv
// Directed bench for uart_serdes with CLKS_PER_BIT=16: byte scoreboards for TX and RX,
// cycle-exact TX timing checks, glitch/framing/reset/full-duplex scenarios.
module tb_uart_serdes;
  import uart_pkg::*;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;
  logic [7:0] data_in = 8'h00;
  logic       data_send = 1'b0;
  logic       data_sent;
  logic [7:0] data_out;
  logic       data_received;
  logic       frame_error;

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  logic       tm_prev;
  logic [9:0] tm_cap;
  bit         tm_abort;
  logic [7:0] tm_exp;
  logic [7:0] rm_exp;

  uart_serdes #(.CLKS_PER_BIT(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rxd      (uart_rxd),
    .uart_txd      (uart_txd),
    .data_in       (data_in),
    .data_send     (data_send),
    .data_sent     (data_sent),
    .data_out      (data_out),
    .data_received (data_received),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request one frame (optionally holding data_send for a back-to-back frame) and check exact timing.
  task automatic tx_exact(input logic [7:0] b, input bit hold, input logic [7:0] b_next);
    int bad;
    logic e;
    data_in = b;
    data_send = 1'b1;
    tx_q.push_back(b);
    @(negedge clk);                    // cycle t0
    if (hold) begin
      data_in = b_next;
      tx_q.push_back(b_next);
    end else begin
      data_send = 1'b0;
    end
    bad = 0;
    for (int c = 1; c <= 10 * N; c++) begin
      @(negedge clk);
      if (c <= N) e = 1'b0;
      else if (c <= 9 * N) e = b[(c - 1) / N - 1];
      else e = 1'b1;
      if (uart_txd !== e) bad++;
      if (data_sent !== 1'b0) bad++;
    end
    check("tx_wave", 32'(bad), 32'd0);
    @(negedge clk);                    // t0+10N+1
    check("tx_sent_pulse", 32'(data_sent), 32'd1);
    @(negedge clk);                    // t0+10N+2
    data_send = 1'b0;
    check("tx_sent_one_cycle", 32'(data_sent), 32'd0);
    @(negedge clk);                    // t0+10N+3
    check("tx_next_start", 32'(uart_txd), hold ? 32'd0 : 32'd1);
  endtask

  task automatic wait_sent(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (data_sent === 1'b1) seen = 1'b1;
    end
    check("tx_sent_seen", 32'(seen), 32'd1);
  endtask

  task automatic drive_rx(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    if (stop_ok) rx_q.push_back(b);
    else ferr_exp++;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (N) @(negedge clk);
    end
  endtask

  // TX monitor: decode frames at mid-bit and score them against the queue.
  initial begin : tx_monitor
    tm_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && tm_prev === 1'b1 && uart_txd === 1'b0) begin
        tm_abort = 1'b0;
        tm_cap = '0;
        for (int c = 1; c <= N / 2 + 9 * N; c++) begin
          @(negedge clk);
          if (rst) tm_abort = 1'b1;
          if (c >= N / 2 && ((c - N / 2) % N) == 0) tm_cap[(c - N / 2) / N] = uart_txd;
        end
        if (!tm_abort) begin
          check("tx_start_bit", 32'(tm_cap[0]), 32'd0);
          check("tx_stop_bit", 32'(tm_cap[9]), 32'd1);
          check("tx_q_nonempty", 32'(tx_q.size() > 0), 32'd1);
          if (tx_q.size() > 0) begin
            tm_exp = tx_q.pop_front();
            check("tx_byte", 32'(tm_cap[8:1]), 32'(tm_exp));
          end
        end
      end
      tm_prev = uart_txd;
    end
  end

  // RX monitor: score every data_received pulse, count frame errors.
  initial begin : rx_monitor
    forever begin
      @(negedge clk);
      if (frame_error === 1'b1) ferr_seen++;
      if (data_received === 1'b1) begin
        check("rx_no_dual_pulse", 32'(frame_error), 32'd0);
        check("rx_q_nonempty", 32'(rx_q.size() > 0), 32'd1);
        if (rx_q.size() > 0) begin
          rm_exp = rx_q.pop_front();
          check("rx_byte", 32'(data_out), 32'(rm_exp));
        end
      end
    end
  end

  initial begin : stimulus
    // Reset values
    wait_cyc(3);
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_sent", 32'(data_sent), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_received", 32'(data_received), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    rst = 1'b0;
    wait_cyc(2);

    // Single frame, then a held request producing a back-to-back frame
    tx_exact(8'hA5, 1'b0, 8'h00);
    wait_cyc(4);
    check("tx_q_drained_1", 32'(tx_q.size()), 32'd0);
    tx_exact(8'h12, 1'b1, 8'hC3);
    wait_sent(12 * N);
    wait_cyc(3);
    check("tx_q_drained_2", 32'(tx_q.size()), 32'd0);
    check("tx_idle_after_hold", 32'(uart_txd), 32'd1);

    // Back-to-back RX frames
    drive_rx(8'h3C, 1'b1);
    drive_rx(8'hFF, 1'b1);
    wait_cyc(4);
    check("rx_q_drained_1", 32'(rx_q.size()), 32'd0);
    check("rx_last_ff", 32'(data_out), 32'hFF);
    check("rx_no_ferr", 32'(ferr_seen), 32'd0);

    // Short glitch is rejected
    uart_rxd = 1'b0;
    wait_cyc(4);
    uart_rxd = 1'b1;
    wait_cyc(2 * N);
    check("rx_glitch_idle", 32'(dut.r_rx_state), 32'(RX_IDLE));
    check("rx_glitch_data_out", 32'(data_out), 32'hFF);

    // Stop bit low, then line held low 40 cycles
    drive_rx(8'h66, 1'b0);
    wait_cyc(40);
    check("rx_ferr_once", 32'(ferr_seen), 32'd1);
    check("rx_ferr_keeps_data", 32'(data_out), 32'hFF);
    check("rx_break_state", 32'(dut.r_rx_state), 32'(RX_BREAK));
    uart_rxd = 1'b1;
    wait_cyc(N);
    check("rx_break_exit", 32'(dut.r_rx_state), 32'(RX_IDLE));

    // Reset mid-TX (bit 3) and mid-RX (bit 5)
    fork
      begin
        logic [9:0] fr;
        fr = {1'b1, 8'h47, 1'b0};
        for (int i = 0; i < 6; i++) begin
          uart_rxd = fr[i];
          wait_cyc(N);
        end
        uart_rxd = fr[6];
        wait_cyc(8);
      end
      begin
        wait_cyc(2 * N);
        data_in = 8'h81;
        data_send = 1'b1;
        @(negedge clk);
        data_send = 1'b0;
      end
    join
    check("pre_rst_txd_low", 32'(uart_txd), 32'd0);
    uart_rxd = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", 32'(uart_txd), 32'd1);
    check("mid_rst_sent", 32'(data_sent), 32'd0);
    check("mid_rst_received", 32'(data_received), 32'd0);
    check("mid_rst_ferr", 32'(frame_error), 32'd0);
    check("mid_rst_data_out", 32'(data_out), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(2);
    check("post_rst_rx_idle", 32'(dut.r_rx_state), 32'(RX_IDLE));
    check("post_rst_tx_idle", 32'(dut.r_tx_state), 32'(TX_IDLE));
    drive_rx(8'h5A, 1'b1);
    wait_cyc(4);
    check("post_rst_rx_byte", 32'(data_out), 32'h5A);
    check("rx_q_drained_2", 32'(rx_q.size()), 32'd0);

    // Full duplex, RX skewed by 7 cycles
    fork
      tx_exact(8'h55, 1'b0, 8'h00);
      begin
        wait_cyc(7);
        drive_rx(8'hAA, 1'b1);
      end
    join
    wait_cyc(4);
    check("duplex_rx_byte", 32'(data_out), 32'hAA);
    check("duplex_tx_q", 32'(tx_q.size()), 32'd0);
    check("duplex_rx_q", 32'(rx_q.size()), 32'd0);
    check("final_ferr", 32'(ferr_seen), 32'(ferr_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
